dbg_inst_encoder: RTL and testbench



---
 rtl/dbg_inst_encoder.sv | 232 +++++++++++++++++++++++
 tb/tb_dbg_inst_encoder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_inst_encoder.sv
// dbg_inst_encoder
// Turns abstract debugger commands (read/write GPR, read/write CSR) into fixed
// sequences of RV32I instruction words. The words go to the core's
// instruction-injection path over a valid/ready handshake.
// Read results are returned through SCRATCH0_ADDR. x31 (TMP_REG) is saved in
// SCRATCH1_ADDR and restored around CSR sequences, so no GPR is corrupted.
//
// Optional feature: define DBG_INST_ENCODER_EBREAK_EN to append EBREAK as the
// last word of every sequence, which returns the core to debug mode.
//
// Ports:
//   clk          clock
//   rst          synchronous reset, active-high
//   cmd_valid_i  command request
//   cmd_ready_o  encoder can accept a command
//   cmd_op_i     0=RD_GPR 1=WR_GPR 2=RD_CSR 3=WR_CSR
//   cmd_addr_i   GPR index in [4:0] for GPR ops, CSR address for CSR ops
//   cmd_wdata_i  write value for WR_GPR / WR_CSR
//   abort_i      cancel the sequence in progress
//   inst_valid_o instruction word valid
//   inst_ready_i core accepts the word
//   inst_o       encoded instruction
//   busy_o       sequence in progress
//   done_o       one-cycle pulse when a sequence completes
module dbg_inst_encoder #(
  parameter logic [11:0] SCRATCH0_ADDR = 12'h7B2,
  parameter logic [11:0] SCRATCH1_ADDR = 12'h7B3,
  parameter logic [4:0]  TMP_REG       = 5'd31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [11:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  input  logic        abort_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_RD_GPR = 2'd0,
    OP_WR_GPR = 2'd1,
    OP_RD_CSR = 2'd2,
    OP_WR_CSR = 2'd3
  } op_e;

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [4:0]  X0     = 5'd0;

  state_e      state_q;
  op_e         op_q;
  logic [11:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  step_q;
  logic [2:0]  step_d;
  logic        inst_valid_q;
  logic [31:0] inst_q;
  logic        ready_q;
  logic        busy_q;
  logic        done_q;

  function automatic logic [31:0] enc_lui(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'h37};
  endfunction

  function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'h13};
  endfunction

  function automatic logic [31:0] enc_csrrw(input logic [4:0] rd, input logic [11:0] csr,
                                            input logic [4:0] rs1);
    return {csr, rs1, 3'b001, rd, 7'h73};
  endfunction

  function automatic logic [31:0] enc_csrrs(input logic [4:0] rd, input logic [11:0] csr,
                                            input logic [4:0] rs1);
    return {csr, rs1, 3'b010, rd, 7'h73};
  endfunction

  // Word 'step' of the sequence for a command. Steps past the base sequence
  // only exist when the trailing EBREAK is enabled, so they map to EBREAK.
  function automatic logic [31:0] word_f(input op_e op, input logic [11:0] addr,
                                         input logic [31:0] wd, input logic [2:0] step);
    logic [19:0] hi;
    logic [11:0] lo;
    logic [4:0]  rg;
    logic [31:0] w;
    // ADDI sign-extends lo, so bump hi when lo[11] is set; wraps mod 2^20.
    hi = wd[31:12] + {19'd0, wd[11]};
    lo = wd[11:0];
    rg = addr[4:0];
    w  = EBREAK;
    case (op)
      OP_WR_GPR: begin
        case (step)
          3'd0:    w = enc_lui(rg, hi);
          3'd1:    w = enc_addi(rg, rg, lo);
          default: w = EBREAK;
        endcase
      end
      OP_RD_GPR: begin
        case (step)
          3'd0:    w = enc_csrrw(X0, SCRATCH0_ADDR, rg);
          default: w = EBREAK;
        endcase
      end
      OP_RD_CSR: begin
        case (step)
          3'd0:    w = enc_csrrw(X0, SCRATCH1_ADDR, TMP_REG);
          3'd1:    w = enc_csrrs(TMP_REG, addr, X0);
          3'd2:    w = enc_csrrw(X0, SCRATCH0_ADDR, TMP_REG);
          3'd3:    w = enc_csrrs(TMP_REG, SCRATCH1_ADDR, X0);
          default: w = EBREAK;
        endcase
      end
      OP_WR_CSR: begin
        case (step)
          3'd0:    w = enc_csrrw(X0, SCRATCH1_ADDR, TMP_REG);
          3'd1:    w = enc_lui(TMP_REG, hi);
          3'd2:    w = enc_addi(TMP_REG, TMP_REG, lo);
          3'd3:    w = enc_csrrw(X0, addr, TMP_REG);
          3'd4:    w = enc_csrrs(TMP_REG, SCRATCH1_ADDR, X0);
          default: w = EBREAK;
        endcase
      end
      default: w = EBREAK;
    endcase
    return w;
  endfunction

  function automatic logic [2:0] last_step_f(input op_e op);
    logic [2:0] n;
    case (op)
      OP_RD_GPR: n = 3'd0;
      OP_WR_GPR: n = 3'd1;
      OP_RD_CSR: n = 3'd3;
      OP_WR_CSR: n = 3'd4;
      default:   n = 3'd0;
    endcase
`ifdef DBG_INST_ENCODER_EBREAK_EN
    n = n + 3'd1;
`else
    n = n + 3'd0;
`endif
    return n;
  endfunction

  assign step_d = step_q + 3'd1;

  // Outputs are registered; the next word is encoded when the current one is
  // accepted so inst_o only changes on a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= OP_RD_GPR;
      addr_q       <= '0;
      wdata_q      <= '0;
      step_q       <= '0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (cmd_valid_i && ready_q) begin
            op_q         <= op_e'(cmd_op_i);
            addr_q       <= cmd_addr_i;
            wdata_q      <= cmd_wdata_i;
            step_q       <= '0;
            inst_q       <= word_f(op_e'(cmd_op_i), cmd_addr_i, cmd_wdata_i, 3'd0);
            inst_valid_q <= 1'b1;
            ready_q      <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (abort_i) begin
            inst_valid_q <= 1'b0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end else if (inst_ready_i) begin
            if (step_q == last_step_f(op_q)) begin
              inst_valid_q <= 1'b0;
              done_q       <= 1'b1;
              state_q      <= S_DONE;
            end else begin
              step_q <= step_d;
              inst_q <= word_f(op_q, addr_q, wdata_q, step_d);
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          inst_valid_q <= 1'b0;
          ready_q      <= 1'b1;
          busy_q       <= 1'b0;
          done_q       <= 1'b0;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o  = ready_q;
  assign inst_valid_o = inst_valid_q;
  assign inst_o       = inst_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_dbg_inst_encoder.sv
// Scoreboard bench for dbg_inst_encoder: expected words are queued when a
// command is driven and compared on every cycle the DUT presents a word.
module tb_dbg_inst_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [1:0]  cmd_op_i;
  logic [11:0] cmd_addr_i;
  logic [31:0] cmd_wdata_i;
  logic        abort_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic        busy_o;
  logic        done_o;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] exp_q[$];

  dbg_inst_encoder #(
    .SCRATCH0_ADDR(12'h7B2),
    .SCRATCH1_ADDR(12'h7B3),
    .TMP_REG      (5'd31)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_op_i    (cmd_op_i),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_wdata_i (cmd_wdata_i),
    .abort_i     (abort_i),
    .inst_valid_o(inst_valid_o),
    .inst_ready_i(inst_ready_i),
    .inst_o      (inst_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Every presented word must equal the head of the queue (this also proves
  // the word is held while ready is low); pop on handshake.
  always @(negedge clk) begin
    if (!rst && inst_valid_o) begin
      if (exp_q.size() == 0) begin
        chk("word_unexpected", {31'd0, inst_valid_o}, 32'd0);
      end else begin
        chk("inst_word", inst_o, exp_q[0]);
        if (inst_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  task automatic push_ebreak();
`ifdef DBG_INST_ENCODER_EBREAK_EN
    exp_q.push_back(EBREAK);
`endif
  endtask

  // Called just after a posedge with the expected words already queued.
  task automatic run_cmd(input logic [1:0] op, input logic [11:0] addr,
                         input logic [31:0] wd, input bit tog);
    int unsigned n;
    int unsigned low;
    int unsigned dones;
    int unsigned cyc;
    bit          ph;
    n = exp_q.size();
    cmd_valid_i  = 1'b1;
    cmd_op_i     = op;
    cmd_addr_i   = addr;
    cmd_wdata_i  = wd;
    inst_ready_i = 1'b1;
    @(negedge clk);
    chk("cmd_ready_idle", {31'd0, cmd_ready_o}, 32'd1);
    @(posedge clk); #1;
    // scramble inputs after capture; they must have no effect
    cmd_valid_i = 1'b0;
    cmd_op_i    = 2'($urandom);
    cmd_addr_i  = 12'($urandom);
    cmd_wdata_i = $urandom;
    low = 0; dones = 0; cyc = 0; ph = 1'b1;
    while (!cmd_ready_o && cyc < 60) begin
      inst_ready_i = tog ? ph : 1'b1;
      ph = ~ph;
      @(negedge clk);
      if (cyc == 0) chk("busy_emit", {31'd0, busy_o}, 32'd1);
      low++;
      if (done_o) begin
        dones++;
        chk("done_after_last", exp_q.size(), 32'd0);
      end
      @(posedge clk); #1;
      cyc++;
    end
    inst_ready_i = 1'b1;
    chk("ready_low_cycles", low, tog ? (2 * n - 1 + 1) : (n + 1));
    chk("done_pulses", dones, 32'd1);
    chk("queue_drained", exp_q.size(), 32'd0);
    chk("busy_idle", {31'd0, busy_o}, 32'd0);
  endtask

  // Independent formulation of the split: round wdata to the nearest 4 KiB.
  task automatic push_wr_gpr(input logic [4:0] rg, input logic [31:0] wd);
    logic [31:0] r;
    r = wd + 32'h800;
    exp_q.push_back({r[31:12], rg, 7'h37});
    exp_q.push_back({wd[11:0], rg, 3'b000, rg, 7'h13});
    push_ebreak();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] wd;
    logic [4:0]  rg;
    logic [11:0] ad;
    rst = 1'b1; cmd_valid_i = 1'b0; cmd_op_i = '0; cmd_addr_i = '0;
    cmd_wdata_i = '0; abort_i = 1'b0; inst_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, cmd_ready_o}, 32'd1);
    chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("rst_inst", inst_o, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // WR_GPR x5 = 0x12345FFF
    exp_q.push_back(32'h123462B7);
    exp_q.push_back(32'hFFF28293);
    push_ebreak();
    run_cmd(2'd1, 12'd5, 32'h12345FFF, 1'b0);

    // RD_GPR x10
    exp_q.push_back(32'h7B251073);
    push_ebreak();
    run_cmd(2'd0, 12'd10, 32'h0, 1'b0);

    // RD_CSR mepc
    exp_q.push_back(32'h7B3F9073);
    exp_q.push_back(32'h34102FF3);
    exp_q.push_back(32'h7B2F9073);
    exp_q.push_back(32'h7B302FF3);
    push_ebreak();
    run_cmd(2'd2, 12'h341, 32'h0, 1'b0);

    // WR_CSR mtvec = 0x800 (carry into hi), ready toggling
    exp_q.push_back(32'h7B3F9073);
    exp_q.push_back(32'h00001FB7);
    exp_q.push_back(32'h800F8F93);
    exp_q.push_back(32'h305F9073);
    exp_q.push_back(32'h7B302FF3);
    push_ebreak();
    run_cmd(2'd3, 12'h305, 32'h00000800, 1'b1);

    // hi wraps: 0xFFFFF800 -> hi=0, lo=0x800; also rg=0 with upper addr bits set
    push_wr_gpr(5'd0, 32'hFFFFF800);
    run_cmd(2'd1, 12'hFE0, 32'hFFFFF800, 1'b0);

    for (int i = 0; i < 4; i++) begin
      wd = $urandom;
      rg = 5'($urandom_range(0, 31));
      ad = {7'($urandom), rg};
      push_wr_gpr(rg, wd);
      run_cmd(2'd1, ad, wd, (i % 2) == 1);
    end

    // abort during 3rd word of WR_CSR (that word is accepted in the same cycle)
    exp_q.push_back(32'h7B3F9073);
    exp_q.push_back(32'h00001FB7);
    exp_q.push_back(32'h800F8F93);
    cmd_valid_i = 1'b1; cmd_op_i = 2'd3; cmd_addr_i = 12'h305;
    cmd_wdata_i = 32'h00000800; inst_ready_i = 1'b1;
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    chk("abort_q_used", exp_q.size(), 32'd0);
    exp_q.delete();
    chk("abort_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("abort_ready", {31'd0, cmd_ready_o}, 32'd1);
    chk("abort_done", {31'd0, done_o}, 32'd0);
    @(negedge clk);
    chk("abort_no_done", {31'd0, done_o}, 32'd0);
    @(posedge clk); #1;
    exp_q.push_back(32'h7B251073);
    push_ebreak();
    run_cmd(2'd0, 12'd10, 32'h0, 1'b0);

    // reset mid RD_CSR
    exp_q.push_back(32'h7B3F9073);
    exp_q.push_back(32'h34102FF3);
    cmd_valid_i = 1'b1; cmd_op_i = 2'd2; cmd_addr_i = 12'h341; inst_ready_i = 1'b1;
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    chk("mid_rst_ready", {31'd0, cmd_ready_o}, 32'd1);
    chk("mid_rst_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("mid_rst_inst", inst_o, 32'd0);
    chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    chk("mid_rst_done", {31'd0, done_o}, 32'd0);

    exp_q.push_back(32'h7B251073);
    push_ebreak();
    run_cmd(2'd0, 12'd10, 32'h0, 1'b0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
